// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, opcode constants, ALUOp and datapath mux select encodings.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALUOp values are shared with the single-cycle ALU decoder.
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ITYPE = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;

    localparam logic [1:0] PC_ALU       = 2'b00;
    localparam logic [1:0] PC_ALUOUT    = 2'b01;
    localparam logic [1:0] PC_ALU_ALIGN = 2'b10;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_R:                     return S_EXEC_R;
            OP_I, OP_LUI, OP_AUIPC:   return S_EXEC_I;
            OP_LOAD, OP_STORE:        return S_MEM_ADDR;
            OP_BRANCH:                return S_BRANCH;
            OP_JAL, OP_JALR:          return S_JUMP;
            default:                  return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: opcode/comparator/memory-ready inputs plus
// every enable and mux select the control unit drives.
interface multicycle_control_if;
    // Memory handshake: mem_read/mem_write stay asserted (with a stable i_or_d)
    // until a cycle where mem_ready is high; that cycle completes the transfer.
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       bus_err;
    logic [3:0] state_o;

    modport master (
        input  opcode, branch_taken, mem_ready,
        output pc_write, ir_write, pc_src, alu_src_a, alu_src_b, alu_op,
               mem_read, mem_write, i_or_d, reg_write, wb_sel,
               illegal, bus_err, state_o
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  pc_write, ir_write, pc_src, alu_src_a, alu_src_b, alu_op,
               mem_read, mem_write, i_or_d, reg_write, wb_sel,
               illegal, bus_err, state_o
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive not-ready cycles of an outstanding memory access and
// flags a timeout when WAIT_LIMIT waits have elapsed (WAIT_LIMIT = 0 disables).
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);
    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [CW-1:0] count;

    // A completed transfer or any non-memory state clears the count, so every
    // memory state is entered with a fresh count of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (active && !mem_ready) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

    assign timeout = (WAIT_LIMIT != 0) && active && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM. Optional performance counters are enabled
// with the MULTICYCLE_PERF_CNT_EN macro.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH = 32
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   bus
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]   cycle_cnt,
    output logic [CNT_WIDTH-1:0]   instret_cnt
`endif
);
    state_t     state;
    logic       illegal_q;
    logic       bus_err_q;
    logic       timeout;
    logic       mem_active;

    logic       pc_write_c;
    logic       ir_write_c;
    logic [1:0] pc_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [2:0] alu_op_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       i_or_d_c;
    logic       reg_write_c;
    logic [1:0] wb_sel_c;

    assign mem_active = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (mem_active),
        .mem_ready (bus.mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    // mem_ready wins over a timeout reached in the same cycle.
                    if (bus.mem_ready) begin
                        case (state)
                            S_FETCH:  state <= S_DECODE;
                            S_MEM_RD: state <= S_WB_MEM;
                            default:  state <= S_FETCH;
                        endcase
                    end else if (timeout) begin
                        state     <= S_TRAP;
                        bus_err_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state <= decode_next(bus.opcode);
                    if (decode_next(bus.opcode) == S_TRAP) illegal_q <= 1'b1;
                end
                S_EXEC_R, S_EXEC_I: state <= S_WB_ALU;
                S_MEM_ADDR: state <= (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state <= S_FETCH;
                S_TRAP: state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        pc_src_c    = PC_ALU;
        alu_src_a_c = SRC_A_RS1;
        alu_src_b_c = SRC_B_RS2;
        alu_op_c    = ALU_ADD;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        i_or_d_c    = 1'b0;
        reg_write_c = 1'b0;
        wb_sel_c    = WB_ALUOUT;
        case (state)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_a_c = SRC_A_PC;
                alu_src_b_c = SRC_B_FOUR;
                pc_write_c  = bus.mem_ready;
                ir_write_c  = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a_c = SRC_A_PC;
                alu_src_b_c = SRC_B_IMM;
            end
            S_EXEC_R: alu_op_c = ALU_RTYPE;
            S_EXEC_I: begin
                alu_src_b_c = SRC_B_IMM;
                case (bus.opcode)
                    OP_LUI: begin
                        alu_src_a_c = SRC_A_ZERO;
                        alu_op_c    = ALU_LUI;
                    end
                    OP_AUIPC: alu_src_a_c = SRC_A_PC;
                    default:  alu_op_c    = ALU_ITYPE;
                endcase
            end
            S_MEM_ADDR: alu_src_b_c = SRC_B_IMM;
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
            end
            S_WB_ALU: reg_write_c = 1'b1;
            S_WB_MEM: begin
                reg_write_c = 1'b1;
                wb_sel_c    = WB_MDR;
            end
            S_BRANCH: begin
                alu_op_c   = ALU_SUB;
                pc_src_c   = PC_ALUOUT;
                pc_write_c = bus.branch_taken;
            end
            S_JUMP: begin
                reg_write_c = 1'b1;
                wb_sel_c    = WB_PC4;
                pc_write_c  = 1'b1;
                if (bus.opcode == OP_JALR) begin
                    alu_src_b_c = SRC_B_IMM;
                    pc_src_c    = PC_ALU_ALIGN;
                end else begin
                    pc_src_c    = PC_ALUOUT;
                end
            end
            default: ;
        endcase
        // Reset must abort any in-flight access without waiting for a clock.
        if (!rst_n) begin
            pc_write_c  = 1'b0;
            ir_write_c  = 1'b0;
            mem_read_c  = 1'b0;
            mem_write_c = 1'b0;
            reg_write_c = 1'b0;
        end
    end

    assign bus.pc_write  = pc_write_c;
    assign bus.ir_write  = ir_write_c;
    assign bus.pc_src    = pc_src_c;
    assign bus.alu_src_a = alu_src_a_c;
    assign bus.alu_src_b = alu_src_b_c;
    assign bus.alu_op    = alu_op_c;
    assign bus.mem_read  = mem_read_c;
    assign bus.mem_write = mem_write_c;
    assign bus.i_or_d    = i_or_d_c;
    assign bus.reg_write = reg_write_c;
    assign bus.wb_sel    = wb_sel_c;
    assign bus.illegal   = illegal_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.state_o   = state;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic retire;

    // Every path back into FETCH from elsewhere completes one instruction.
    assign retire = (state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_BRANCH) ||
                    (state == S_JUMP) || ((state == S_MEM_WR) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control vectors
// are queued as each cycle is driven and checked at the falling edge.
module tb_multicycle_control;
    localparam int W = 23;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_I      = 7'b0010011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_JALR   = 7'b1100111;
    localparam logic [6:0] T_LUI    = 7'b0110111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic exp_ill;
    logic exp_berr;
    logic [W-1:0] exp_q[$];

    multicycle_control_if bus ();

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
    int          exp_cyc;
    int          exp_ret;
    logic [3:0]  prev_st;
    logic        have_prev;
`endif

    multicycle_control #(.WAIT_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MULTICYCLE_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] mk(input logic [3:0] st, input logic pcw, input logic irw,
                                        input logic [1:0] pcs, input logic [1:0] a,
                                        input logic [1:0] b, input logic [2:0] op,
                                        input logic mr, input logic mw, input logic iod,
                                        input logic rw, input logic [1:0] wbs);
        return {st, pcw, irw, pcs, a, b, op, mr, mw, iod, rw, wbs, exp_ill, exp_berr};
    endfunction

    function automatic logic [W-1:0] f_fetch(input logic r);
        return mk(4'd0, r, r, 2'b00, 2'b01, 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction

    function automatic logic [W-1:0] f_dec();
        return mk(4'd1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction

    function automatic logic [W-1:0] f_trap();
        return mk(4'd11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction

    function automatic logic [W-1:0] f_wb_alu();
        return mk(4'd7, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    endfunction

    function automatic logic [W-1:0] observed();
        return {bus.state_o, bus.pc_write, bus.ir_write, bus.pc_src, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.mem_read, bus.mem_write, bus.i_or_d,
                bus.reg_write, bus.wb_sel, bus.illegal, bus.bus_err};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_ill  = 1'b0;
        exp_berr = 1'b0;
`ifdef MULTICYCLE_PERF_CNT_EN
        exp_cyc   = 0;
        exp_ret   = 0;
        have_prev = 1'b0;
`endif
    endtask

    // Enables, requests, flags and state must all read zero while rst_n is low.
    task automatic chk_reset(input string tag);
        logic [W-1:0] obs;
        obs = W'({bus.state_o, bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write,
                  bus.reg_write, bus.illegal, bus.bus_err});
        chk(tag, obs, '0);
    endtask

    // Called at posedge+1; drives this cycle's inputs, checks at negedge,
    // returns at the next posedge+1.
    task automatic step(input string tag, input logic rdy, input logic tk,
                        input logic [W-1:0] exp);
        logic [W-1:0] e;
        exp_q.push_back(exp);
        bus.mem_ready    = rdy;
        bus.branch_taken = tk;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, observed(), e);
`ifdef MULTICYCLE_PERF_CNT_EN
            if (have_prev) begin
                if (prev_st != 4'd11) exp_cyc++;
                if (prev_st != 4'd0 && e[W-1 -: 4] == 4'd0) exp_ret++;
            end
            chk({tag, "_cyc"}, W'(cycle_cnt), W'(exp_cyc));
            chk({tag, "_ret"}, W'(instret_cnt), W'(exp_ret));
            prev_st   = e[W-1 -: 4];
            have_prev = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_model();
        rst_n            = 1'b0;
        bus.opcode       = 7'd0;
        bus.mem_ready    = 1'b0;
        bus.branch_taken = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        release_reset();

        // ADD: 0,1,2,7 with reg_write only in the fourth cycle
        bus.opcode = T_R;
        step("add_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("add_dec",   1'b1, 1'b0, f_dec());
        step("add_exec",  1'b1, 1'b0, mk(4'd2, 0, 0, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0, 0, 0, 2'b00));
        step("add_wb",    1'b1, 1'b0, f_wb_alu());

        // LW with three wait cycles in MEM_RD: 8 cycles total
        bus.opcode = T_LOAD;
        step("lw_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("lw_dec",   1'b1, 1'b0, f_dec());
        step("lw_addr",  1'b1, 1'b0, mk(4'd4, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0, 0, 0, 2'b00));
        for (int i = 0; i < 3; i++)
            step("lw_wait", 1'b0, 1'b0, mk(4'd5, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0, 1, 0, 2'b00));
        step("lw_rd",    1'b1, 1'b0, mk(4'd5, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0, 1, 0, 2'b00));
        step("lw_wb",    1'b1, 1'b0, mk(4'd8, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, 1, 2'b01));

        // BEQ taken, then BNE not taken
        bus.opcode = T_BRANCH;
        step("beq_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("beq_dec",   1'b1, 1'b0, f_dec());
        step("beq_br",    1'b1, 1'b1, mk(4'd9, 1, 0, 2'b01, 2'b00, 2'b00, 3'b001, 0, 0, 0, 0, 2'b00));
        step("bne_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("bne_dec",   1'b1, 1'b0, f_dec());
        step("bne_br",    1'b1, 1'b0, mk(4'd9, 0, 0, 2'b01, 2'b00, 2'b00, 3'b001, 0, 0, 0, 0, 2'b00));

        // JALR and JAL
        bus.opcode = T_JALR;
        step("jalr_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("jalr_dec",   1'b1, 1'b0, f_dec());
        step("jalr_jump",  1'b1, 1'b0, mk(4'd10, 1, 0, 2'b10, 2'b00, 2'b01, 3'b000, 0, 0, 0, 1, 2'b10));
        bus.opcode = T_JAL;
        step("jal_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("jal_dec",   1'b1, 1'b0, f_dec());
        step("jal_jump",  1'b1, 1'b0, mk(4'd10, 1, 0, 2'b01, 2'b00, 2'b00, 3'b000, 0, 0, 0, 1, 2'b10));

        // LUI, AUIPC, ADDI through EXEC_I
        bus.opcode = T_LUI;
        step("lui_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("lui_dec",   1'b1, 1'b0, f_dec());
        step("lui_exec",  1'b1, 1'b0, mk(4'd3, 0, 0, 2'b00, 2'b10, 2'b01, 3'b100, 0, 0, 0, 0, 2'b00));
        step("lui_wb",    1'b1, 1'b0, f_wb_alu());
        bus.opcode = T_AUIPC;
        step("auipc_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("auipc_dec",   1'b1, 1'b0, f_dec());
        step("auipc_exec",  1'b1, 1'b0, mk(4'd3, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 0, 0, 0, 2'b00));
        step("auipc_wb",    1'b1, 1'b0, f_wb_alu());
        bus.opcode = T_I;
        step("addi_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("addi_dec",   1'b1, 1'b0, f_dec());
        step("addi_exec",  1'b1, 1'b0, mk(4'd3, 0, 0, 2'b00, 2'b00, 2'b01, 3'b011, 0, 0, 0, 0, 2'b00));
        step("addi_wb",    1'b1, 1'b0, f_wb_alu());

        // SW with one wait cycle
        bus.opcode = T_STORE;
        step("sw_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("sw_dec",   1'b1, 1'b0, f_dec());
        step("sw_addr",  1'b1, 1'b0, mk(4'd4, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0, 0, 0, 2'b00));
        step("sw_wait",  1'b0, 1'b0, mk(4'd6, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, 1, 0, 2'b00));
        step("sw_wr",    1'b1, 1'b0, mk(4'd6, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, 1, 0, 2'b00));

        // Fetch answered exactly at the wait limit: ready wins, no bus error
        bus.opcode = T_R;
        for (int i = 0; i < 4; i++)
            step("lim_wait", 1'b0, 1'b0, f_fetch(1'b0));
        step("lim_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("lim_dec",   1'b1, 1'b0, f_dec());
        step("lim_exec",  1'b1, 1'b0, mk(4'd2, 0, 0, 2'b00, 2'b00, 2'b00, 3'b010, 0, 0, 0, 0, 2'b00));
        step("lim_wb",    1'b1, 1'b0, f_wb_alu());

        // Reset during MEM_WR must drop the write immediately
        bus.opcode = T_STORE;
        step("abort_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("abort_dec",   1'b1, 1'b0, f_dec());
        step("abort_addr",  1'b1, 1'b0, mk(4'd4, 0, 0, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0, 0, 0, 2'b00));
        bus.mem_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("abort_rst");
        release_reset();

        // Illegal opcode: TRAP with illegal set, nothing enabled for 20 cycles
        bus.opcode = 7'b1111111;
        step("ill_fetch", 1'b1, 1'b0, f_fetch(1'b1));
        step("ill_dec",   1'b1, 1'b0, f_dec());
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++)
            step("ill_trap", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f_trap());
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("ill_clear");
        release_reset();

        // Fetch stuck not-ready: bus error after the fifth unanswered cycle
        bus.opcode = T_R;
        for (int i = 0; i < 5; i++)
            step("to_wait", 1'b0, 1'b0, f_fetch(1'b0));
        exp_berr = 1'b1;
        for (int i = 0; i < 4; i++)
            step("to_trap", 1'($urandom_range(0, 1)), 1'b0, f_trap());
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("to_clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
